// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction sequencer: feeds one external full-subtractor cell LSB first,
// shifts its difference bits into diff and recirculates its borrow for WIDTH cycles.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             fs_x,
  output logic             fs_y,
  output logic             fs_z,
  input  logic             fs_d,
  input  logic             fs_b
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CNT_W-1:0] count;
  logic             borrow_q;

  // The shift registers are empty after WIDTH shifts and borrow_q is cleared on the
  // last edge, so the cell inputs are plain flop outputs that read 0 outside RUN.
  assign fs_x = a_sh[0];
  assign fs_y = b_sh[0];
  assign fs_z = borrow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      count      <= '0;
      borrow_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            state      <= S_RUN;
            busy       <= 1'b1;
            a_sh       <= a;
            b_sh       <= b;
            borrow_q   <= 1'b0;
            count      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          diff  <= {fs_d, diff[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          count <= count + 1'b1;
          if (count == LAST_CNT) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            borrow_out <= fs_b;
            borrow_q   <= 1'b0;
          end else begin
            borrow_q <= fs_b;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl with a behavioural full-subtractor cell.
module tb_serial_sub_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, borrow_out;
  logic [WIDTH-1:0] diff;
  logic             fs_x, fs_y, fs_z, fs_d, fs_b;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bo;
    int unsigned      c;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned busy_len = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  serial_sub_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
    .fs_x(fs_x), .fs_y(fs_y), .fs_z(fs_z), .fs_d(fs_d), .fs_b(fs_b)
  );

  // external full-subtractor cell
  assign fs_d = fs_x ^ fs_y ^ fs_z;
  assign fs_b = (~fs_x & fs_y) | (~fs_x & fs_z) | (fs_y & fs_z);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_len = 0;
    end else begin
      if (busy) busy_len++;
      if (busy && done) check("busy_and_done", 32'(busy & done), 32'd0);
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("diff", 32'(diff), 32'(e.d));
          check("borrow_out", 32'(borrow_out), 32'(e.bo));
          check("done_cycle", cyc, e.c + WIDTH);
          check("busy_len", busy_len, WIDTH);
        end
        busy_len = 0;
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [WIDTH-1:0] ed, input logic eb, input bit push);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    if (push) q.push_back('{d: ed, bo: eb, c: cyc + 1});
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
  endtask

  task automatic wait_done(output logic zacc);
    bit seen;
    seen = 1'b0;
    zacc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      zacc = zacc | fs_z;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    logic zacc;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic zacc;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_fs", 32'({fs_x, fs_y, fs_z, borrow_out}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic vectors
    issue(8'h5A, 8'h23, 8'h37, 1'b0, 1'b1); wait_done(zacc);
    issue(8'h10, 8'h20, 8'hF0, 1'b1, 1'b1); wait_done(zacc);
    issue(8'h00, 8'h01, 8'hFF, 1'b1, 1'b1); wait_done(zacc);
    issue(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1); wait_done(zacc);
    check("fs_z_quiet", 32'(zacc), 32'd0);
    repeat (2) @(negedge clk);

    // start and new operands mid-RUN are ignored
    issue(8'h0F, 8'h0A, 8'h05, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'h00; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(zacc);
    repeat (3) @(negedge clk);

    // reset mid-RUN aborts without a done
    issue(8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_fs", 32'({fs_x, fs_y, fs_z}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'h01, 8'h02, 8'hFF, 1'b1, 1'b1); wait_done(zacc);

    // start held high: back-to-back accept from DONE
    @(negedge clk);
    start = 1'b1; a = 8'h33; b = 8'h11;
    q.push_back('{d: 8'h22, bo: 1'b0, c: cyc + 1});
    @(posedge clk);
    #1;
    a = 8'h80; b = 8'h01;
    wait_done(zacc);
    q.push_back('{d: 8'h7F, bo: 1'b0, c: cyc + 1});
    @(posedge clk);
    #1;
    start = 1'b0;
    check("reaccept_busy", 32'(busy), 32'd1);
    wait_done(zacc);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
